// File: rtl/mbist_pkg.sv
// Shared types and March algorithm tables for the memory BIST controller.
// Each element lists up to two operations; ops[0] is issued first at every address.
package mbist_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  typedef enum logic {AlgoMarchC = 1'b0, AlgoMatsPlus = 1'b1} algo_e;

  typedef struct packed {
    logic rd;   // 1 = read-and-compare, 0 = write
    logic inv;  // operate on the complemented background
  } op_t;

  typedef struct packed {
    logic       down;
    logic [1:0] nops;
    op_t  [1:0] ops;
  } elem_t;

  localparam int unsigned MaxDw    = 64;
  localparam int unsigned MaxElems = 8;

  localparam op_t OpWD  = '{rd: 1'b0, inv: 1'b0};
  localparam op_t OpWDn = '{rd: 1'b0, inv: 1'b1};
  localparam op_t OpRD  = '{rd: 1'b1, inv: 1'b0};
  localparam op_t OpRDn = '{rd: 1'b1, inv: 1'b1};

  localparam elem_t ElemNone = '{down: 1'b0, nops: 2'd1, ops: {OpWD, OpWD}};

  localparam elem_t MarchCElems [MaxElems] = '{
    '{down: 1'b0, nops: 2'd1, ops: {OpWD,  OpWD}},
    '{down: 1'b0, nops: 2'd2, ops: {OpWDn, OpRD}},
    '{down: 1'b0, nops: 2'd2, ops: {OpWD,  OpRDn}},
    '{down: 1'b1, nops: 2'd2, ops: {OpWDn, OpRD}},
    '{down: 1'b1, nops: 2'd2, ops: {OpWD,  OpRDn}},
    '{down: 1'b0, nops: 2'd1, ops: {OpRD,  OpRD}},
    ElemNone,
    ElemNone
  };

  localparam elem_t MatsPlusElems [MaxElems] = '{
    '{down: 1'b0, nops: 2'd1, ops: {OpWD,  OpWD}},
    '{down: 1'b0, nops: 2'd2, ops: {OpWDn, OpRD}},
    '{down: 1'b1, nops: 2'd2, ops: {OpWD,  OpRDn}},
    ElemNone,
    ElemNone,
    ElemNone,
    ElemNone,
    ElemNone
  };

  function automatic elem_t get_elem(algo_e algo, logic [2:0] idx);
    return (algo == AlgoMatsPlus) ? MatsPlusElems[idx] : MarchCElems[idx];
  endfunction

  function automatic logic [2:0] elem_count(algo_e algo);
    return (algo == AlgoMatsPlus) ? 3'd3 : 3'd6;
  endfunction

  // Solid background is all-zeros; checkerboard starts with bit 0 set (0x55..).
  function automatic logic [MaxDw-1:0] background(logic chk);
    return chk ? {(MaxDw / 2){2'b01}} : '0;
  endfunction

endpackage

// File: rtl/mbist_march_sram_sp.sv
// Single-port SRAM with synchronous write and combinational read.
// The injection hook forces one read bit high at one word to emulate a stuck-at-1 cell.
module sram_sp #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DW-1:0]         wdata_i,
  input  logic                  inj_en_i,
  input  logic [AW-1:0]         inj_addr_i,
  input  logic [$clog2(DW)-1:0] inj_bit_i,
  output logic [DW-1:0]         rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = mem_q[addr_i];
    if (inj_en_i && (addr_i == inj_addr_i)) begin
      rdata_o[inj_bit_i] = 1'b1;
    end
  end

endmodule

// File: rtl/mbist_march.sv
// Memory BIST wrapper: normal bus access to a single-port SRAM, or a March C- / MATS+ run
// with first-fail capture and a saturating mismatch counter.
module mbist_march
  import mbist_pkg::*;
#(
  parameter int unsigned AW  = 6,
  parameter int unsigned DW  = 8,
  parameter int unsigned FCW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  opr,
  input  logic                  start,
  input  logic                  algo,
  input  logic                  bg_chk,
  input  logic                  csin,
  input  logic                  rwbarin,
  input  logic [AW-1:0]         address,
  input  logic [DW-1:0]         datain,
  input  logic                  inj_en,
  input  logic [AW-1:0]         inj_addr,
  input  logic [$clog2(DW)-1:0] inj_bit,
  output logic [DW-1:0]         dataout,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [AW-1:0]         fail_addr,
  output logic [2:0]            fail_elem,
  output logic [FCW-1:0]        fail_cnt
);

  state_e         state_q, state_d;
  algo_e          algo_q, algo_d;
  logic           bg_q, bg_d;
  logic [2:0]     elem_q, elem_d;
  logic           op_q, op_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  dataout_q, dataout_d;
  logic           fail_q, fail_d;
  logic [AW-1:0]  fail_addr_q, fail_addr_d;
  logic [2:0]     fail_elem_q, fail_elem_d;
  logic [FCW-1:0] fail_cnt_q, fail_cnt_d;

  elem_t         cur_elem;
  op_t           cur_op;
  logic [DW-1:0] bg, exp_data, rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          run_act, mem_we, mismatch, launch, last_op, last_addr;

  assign cur_elem  = get_elem(algo_q, elem_q);
  assign cur_op    = cur_elem.ops[op_q];
  assign bg        = DW'(background(bg_q));
  assign exp_data  = cur_op.inv ? ~bg : bg;
  assign run_act   = (state_q == StRun) && opr;
  assign last_op   = ({1'b0, op_q} == (cur_elem.nops - 2'd1));
  assign last_addr = cur_elem.down ? (addr_q == '0) : (addr_q == '1);
  assign mismatch  = run_act && cur_op.rd && (rdata != exp_data);

  // The bus only reaches the array in IDLE with opr low; reset suppresses any write.
  assign mem_addr  = (state_q == StRun) ? addr_q : address;
  assign mem_wdata = (state_q == StRun) ? exp_data : datain;
  assign mem_we    = rst && (run_act ? !cur_op.rd
                                     : ((state_q == StIdle) && !opr && csin && !rwbarin));

  sram_sp #(
    .AW(AW),
    .DW(DW)
  ) u_sram (
    .clk_i      (clk),
    .we_i       (mem_we),
    .addr_i     (mem_addr),
    .wdata_i    (mem_wdata),
    .inj_en_i   (inj_en),
    .inj_addr_i (inj_addr),
    .inj_bit_i  (inj_bit),
    .rdata_o    (rdata)
  );

  always_comb begin
    state_d     = state_q;
    algo_d      = algo_q;
    bg_d        = bg_q;
    elem_d      = elem_q;
    op_d        = op_q;
    addr_d      = addr_q;
    dataout_d   = dataout_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_cnt_d  = fail_cnt_q;
    launch      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!opr && csin && rwbarin) begin
          dataout_d = rdata;
        end
        launch = opr && start;
      end
      StRun: begin
        if (!opr) begin
          state_d = StIdle;
        end else if (last_op) begin
          op_d = 1'b0;
          if (!last_addr) begin
            addr_d = cur_elem.down ? addr_q - AW'(1) : addr_q + AW'(1);
          end else if (elem_q == elem_count(algo_q) - 3'd1) begin
            state_d = StDone;
          end else begin
            elem_d = elem_q + 3'd1;
            addr_d = get_elem(algo_q, elem_q + 3'd1).down ? '1 : '0;
          end
        end else begin
          op_d = 1'b1;
        end
      end
      StDone: begin
        if (!opr) begin
          state_d = StIdle;
        end else begin
          launch = start;
        end
      end
      default: state_d = StIdle;
    endcase

    if (mismatch) begin
      fail_d = 1'b1;
      if (fail_cnt_q != '1) begin
        fail_cnt_d = fail_cnt_q + FCW'(1);
      end
      if (!fail_q) begin
        fail_addr_d = addr_q;
        fail_elem_d = elem_q;
      end
    end

    if (launch) begin
      state_d     = StRun;
      algo_d      = algo_e'(algo);
      bg_d        = bg_chk;
      elem_d      = '0;
      op_d        = 1'b0;
      addr_d      = get_elem(algo_e'(algo), 3'd0).down ? '1 : '0;
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = '0;
      fail_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      algo_q      <= AlgoMarchC;
      bg_q        <= 1'b0;
      elem_q      <= '0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      dataout_q   <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      algo_q      <= algo_d;
      bg_q        <= bg_d;
      elem_q      <= elem_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      dataout_q   <= dataout_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign dataout   = dataout_q;
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_mbist_march.sv
// Scoreboard bench for mbist_march: a stimulus process pushes expected results computed by a
// behavioural March model; a monitor pops them when dataout updates or done rises.
module tb_mbist_march;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int FCW   = 2;
  localparam int Depth = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          opr = 1'b0, start = 1'b0, algo = 1'b0, bg_chk = 1'b0;
  logic          csin = 1'b0, rwbarin = 1'b0, inj_en = 1'b0;
  logic [AW-1:0] address = '0, inj_addr = '0;
  logic [DW-1:0] datain = '0;
  logic [2:0]    inj_bit = '0;
  logic [DW-1:0] dataout;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [FCW-1:0] fail_cnt;

  mbist_march #(.AW(AW), .DW(DW), .FCW(FCW)) dut (
    .clk(clk), .rst(rst), .opr(opr), .start(start), .algo(algo), .bg_chk(bg_chk),
    .csin(csin), .rwbarin(rwbarin), .address(address), .datain(datain),
    .inj_en(inj_en), .inj_addr(inj_addr), .inj_bit(inj_bit),
    .dataout(dataout), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           fail;
    logic [AW-1:0]  faddr;
    logic [2:0]     felem;
    logic [FCW-1:0] fcnt;
    int             cycles;
  } bist_exp_t;

  bist_exp_t     bist_q[$];
  logic [DW-1:0] rd_q[$];
  int            addr_seq[$];
  logic [DW-1:0] mem_m [Depth];
  int tests = 0;
  int errors = 0;

  // March tables. Op codes: 0 = wD, 1 = w~D, 2 = rD, 3 = r~D, -1 = no op.
  int mc_dir [6]    = '{0, 0, 0, 1, 1, 0};
  int mc_ops [6][2] = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};
  int mp_dir [3]    = '{0, 0, 1};
  int mp_ops [3][2] = '{'{0, -1}, '{2, 1}, '{3, 0}};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name);
    tests++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the whole algorithm on the model memory and queues the expected run result.
  task automatic model_run(input logic alg, input logic chk, input logic ie, input int ia,
                           input int ib, input bit follow);
    bist_exp_t     e;
    logic [DW-1:0] bg, val, r;
    int ne, dir, op, a, nfail;
    bg = chk ? 8'h55 : 8'h00;
    ne = alg ? 3 : 6;
    e.fail = 1'b0; e.faddr = '0; e.felem = '0; e.cycles = 0;
    nfail = 0;
    addr_seq.delete();
    for (int el = 0; el < ne; el++) begin
      dir = alg ? mp_dir[el] : mc_dir[el];
      for (int i = 0; i < Depth; i++) begin
        a = (dir != 0) ? Depth - 1 - i : i;
        for (int k = 0; k < 2; k++) begin
          op = alg ? mp_ops[el][k] : mc_ops[el][k];
          if (op >= 0) begin
            e.cycles++;
            addr_seq.push_back(a);
            val = (op == 1 || op == 3) ? ~bg : bg;
            if (op >= 2) begin
              r = mem_m[a];
              if (ie && (follow || a == ia)) r[ib] = 1'b1;
              if (r !== val) begin
                if (nfail == 0) begin
                  e.faddr = AW'(a);
                  e.felem = 3'(el);
                end
                nfail++;
              end
            end else begin
              mem_m[a] = val;
            end
          end
        end
      end
    end
    e.fail = (nfail > 0);
    e.fcnt = (nfail > 3) ? 2'd3 : FCW'(nfail);
    bist_q.push_back(e);
  endtask

  task automatic begin_run(input logic alg, input logic chk, input logic ie, input int ia,
                           input int ib);
    opr = 1'b1; start = 1'b1; algo = alg; bg_chk = chk;
    inj_en = ie; inj_addr = AW'(ia); inj_bit = 3'(ib);
    tick();
    start = 1'b0;
  endtask

  task automatic run_full(input logic alg, input logic chk, input logic ie, input int ia,
                          input int ib, input bit follow);
    int n;
    model_run(alg, chk, ie, ia, ib, follow);
    begin_run(alg, chk, ie, ia, ib);
    n = 0;
    while (!done && n < 2000) begin
      if (follow && n < addr_seq.size()) inj_addr = AW'(addr_seq[n]);
      start = 1'($urandom_range(0, 1));  // start during RUN must be ignored
      tick();
      n++;
    end
    start = 1'b0;
    if (!done) begin
      fail_note("bist_done_timeout");
      if (bist_q.size() > 0) void'(bist_q.pop_front());
    end
    tick();
    opr = 1'b0; inj_en = 1'b0;
    tick();
    check("done_cleared_after_opr_low", done, 0);
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    csin = 1'b1; rwbarin = 1'b0; address = AW'(a); datain = d;
    mem_m[a] = d;
    tick();
    csin = 1'b0;
  endtask

  task automatic do_read(input int a);
    csin = 1'b1; rwbarin = 1'b1; address = AW'(a);
    rd_q.push_back(mem_m[a]);
    tick();
    csin = 1'b0;
  endtask

  // Monitor: reads are decided from bench-driven inputs at the edge, results checked mid-cycle.
  bit   rd_pend = 1'b0;
  int   busy_cnt = 0;
  logic busy_prev = 1'b0, done_prev = 1'b0;

  always @(posedge clk) rd_pend = rst && !opr && csin && rwbarin;

  always @(negedge clk) begin
    bist_exp_t e;
    logic [DW-1:0] exp_d;
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        fail_note("read_without_expectation");
      end else begin
        exp_d = rd_q.pop_front();
        check("dataout", dataout, exp_d);
      end
    end
    if (busy) busy_cnt = busy_prev ? busy_cnt + 1 : 1;
    if (done && !done_prev) begin
      if (bist_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        e = bist_q.pop_front();
        check("run_cycles", busy_cnt, e.cycles);
        check("fail", fail, e.fail);
        check("fail_addr", fail_addr, e.faddr);
        check("fail_elem", fail_elem, e.felem);
        check("fail_cnt", fail_cnt, e.fcnt);
      end
    end
    busy_prev = busy;
    done_prev = done;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [DW-1:0] old;
    rst = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_fail_elem", fail_elem, 0);
    check("rst_dataout", dataout, 0);
    rst = 1'b1;
    tick();

    // Normal mode: fill, then random mix of reads and writes.
    for (int a = 0; a < Depth; a++) do_write(a, DW'($urandom));
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) != 0) do_read(int'($urandom_range(0, Depth - 1)));
      else do_write(int'($urandom_range(0, Depth - 1)), DW'($urandom));
    end
    // opr high must block a normal write.
    old = mem_m[20];
    opr = 1'b1; csin = 1'b1; rwbarin = 1'b0; address = AW'(20); datain = ~old;
    tick();
    opr = 1'b0; csin = 1'b0;
    do_read(20);
    // start while opr low is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_opr_low", busy, 0);
    do_write(10, 8'hA5);
    do_read(10);
    tick();

    // Abort by dropping opr at cycle 100 of a faulty March C- run.
    begin_run(1'b0, 1'b0, 1'b1, 5, 3);
    repeat (100) tick();
    opr = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_fail", fail, 1);
    check("abort_fail_cnt", fail_cnt, 1);
    check("abort_fail_addr", fail_addr, 5);
    check("abort_fail_elem", fail_elem, 1);

    // Reset mid-run clears every output at the next edge.
    begin_run(1'b0, 1'b0, 1'b1, 5, 3);
    repeat (100) tick();
    rst = 1'b0;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_fail", fail, 0);
    check("midrst_fail_cnt", fail_cnt, 0);
    check("midrst_fail_addr", fail_addr, 0);
    check("midrst_fail_elem", fail_elem, 0);
    check("midrst_dataout", dataout, 0);
    rst = 1'b1; opr = 1'b0; inj_en = 1'b0;
    tick();

    run_full(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);   // clean March C-
    run_full(1'b0, 1'b0, 1'b1, 5, 3, 1'b0);   // stuck bit 3 @5
    run_full(1'b1, 1'b1, 1'b1, 5, 0, 1'b0);   // MATS+ checkerboard, bit 0
    run_full(1'b0, 1'b1, 1'b1, 0, 1, 1'b1);   // fault follows every address: saturation
    for (int i = 0; i < 6; i++) begin
      run_full(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, Depth - 1)), int'($urandom_range(0, DW - 1)),
               bit'($urandom_range(0, 1)));
    end

    // Memory must hold what the last run wrote.
    for (int i = 0; i < 16; i++) do_read(int'($urandom_range(0, Depth - 1)));
    tick();
    if (rd_q.size() != 0 || bist_q.size() != 0) fail_note("scoreboard_not_drained");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
